// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the EX-stage iterative mul/div unit.
// Opcode/funct encodings, FSM states and a small sign-extension helper.
package ex_muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_32  = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Shared 128-bit shift datapath: one shift-add (mul) or
// restoring-subtract (div) step per cycle.
module ex_muldiv_iter
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_i,
  input  logic [2*XLEN-1:0] load_val_i,
  input  logic [XLEN-1:0]   opd_i,
  output logic [2*XLEN-1:0] step_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] mul_nxt;
  logic [2*XLEN-1:0] div_nxt;

  always_comb begin
    hi      = acc_q[2*XLEN-1:XLEN];
    lo      = acc_q[XLEN-1:0];
    // mul: add multiplicand on LSB, carry shifts into the top bit
    sum     = {1'b0, hi} + {1'b0, (lo[0] ? opd_i : {XLEN{1'b0}})};
    mul_nxt = {sum, lo[XLEN-1:1]};
    // div: shift left, keep the difference only if it did not borrow
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    diff    = {1'b0, rem_sh} - {2'b00, opd_i};
    if (diff[XLEN+1])
      div_nxt = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    else
      div_nxt = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    step_o  = div_i ? div_nxt : mul_nxt;
    acc_d   = acc_q;
    if (load_i)
      acc_d = load_val_i;
    else if (step_i)
      acc_d = step_o;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV64M iterative multiply/divide unit in EX: decode, sign handling,
// special cases and the IDLE/CALC/DONE control FSM.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            stall_req_o,
  output logic            busy_o
);

  localparam int W2 = 2 * XLEN;

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] opd_q, opd_d;
  logic [2:0]      f3_q, f3_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;

  logic            is_op, is_op32, m_op, word, is_div, is_rem;
  logic            sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_res;
  logic [W2-1:0]   load_val, step_val;
  logic            load, step;
  logic [W2-1:0]   prod, prod_s;
  logic [XLEN-1:0] dv, dv_s, fin;

  always_comb begin
    is_op   = opcode_i == OPCODE_OP;
    is_op32 = opcode_i == OPCODE_OP_32;
    m_op    = funct7_i == FUNCT7_MULDIV &&
              (is_op || (is_op32 && (funct3_i == F3_MUL || funct3_i[2])));
    word    = is_op32;
    is_div  = funct3_i[2];
    is_rem  = funct3_i[2] & funct3_i[1];
    sgn_a   = !(funct3_i == F3_MULHU || funct3_i == F3_DIVU ||
                funct3_i == F3_REMU);
    sgn_b   = sgn_a && funct3_i != F3_MULHSU;
    if (word) begin
      a_ext   = sgn_a ? sext32(rs1_data_i[31:0]) : {32'b0, rs1_data_i[31:0]};
      b_ext   = sgn_b ? sext32(rs2_data_i[31:0]) : {32'b0, rs2_data_i[31:0]};
      min_val = sext32(32'h8000_0000);
    end else begin
      a_ext   = rs1_data_i;
      b_ext   = rs2_data_i;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    neg_a    = sgn_a & a_ext[XLEN-1];
    neg_b    = sgn_b & b_ext[XLEN-1];
    a_mag    = neg_a ? -a_ext : a_ext;
    b_mag    = neg_b ? -b_ext : b_ext;
    div_zero = is_div && b_ext == '0;
    div_ovf  = is_div && sgn_a && a_ext == min_val && b_ext == '1;
    if (div_zero)
      spec_res = is_rem ? (word ? sext32(rs1_data_i[31:0]) : rs1_data_i) : '1;
    else
      spec_res = is_rem ? '0 : min_val;
    if (!is_div)
      load_val = {{XLEN{1'b0}}, b_mag};
    else if (word)
      load_val = {{XLEN{1'b0}}, a_mag[31:0], 32'b0};
    else
      load_val = {{XLEN{1'b0}}, a_mag};
  end

  // Final result is formed from the last step's output so it can be
  // registered on the CALC->DONE edge.
  always_comb begin
    prod   = word_q ? {{XLEN{1'b0}}, step_val[95:32]} : step_val;
    prod_s = neg_q ? -prod : prod;
    if (f3_q[1])
      dv = step_val[W2-1:XLEN];
    else
      dv = word_q ? {32'b0, step_val[31:0]} : step_val[XLEN-1:0];
    dv_s = neg_q ? -dv : dv;
    fin  = '0;
    if (f3_q[2])
      fin = word_q ? sext32(dv_s[31:0]) : dv_s;
    else if (word_q)
      fin = sext32(prod_s[31:0]);
    else if (f3_q == F3_MUL)
      fin = prod_s[XLEN-1:0];
    else
      fin = prod_s[W2-1:XLEN];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    opd_d       = opd_q;
    f3_d        = f3_q;
    word_d      = word_q;
    neg_d       = neg_q;
    load        = 1'b0;
    step        = 1'b0;
    stall_req_o = 1'b0;
    valid_o     = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (m_op) begin
          stall_req_o = 1'b1;
          f3_d        = funct3_i;
          word_d      = word;
          neg_d       = is_rem ? neg_a : (neg_a ^ neg_b);
          opd_d       = is_div ? b_mag : a_mag;
          if (div_zero || div_ovf) begin
            result_d = spec_res;
            state_d  = MD_DONE;
          end else begin
            load    = 1'b1;
            cnt_d   = word ? CNT_W'(31) : CNT_W'(XLEN - 1);
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        stall_req_o = 1'b1;
        step        = 1'b1;
        if (cnt_q == '0) begin
          result_d = fin;
          state_d  = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: begin
        valid_o = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) begin
      state_d     = MD_IDLE;
      cnt_d       = '0;
      result_d    = result_q;
      load        = 1'b0;
      step        = 1'b0;
      stall_req_o = 1'b0;
      valid_o     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      opd_q    <= '0;
      f3_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      opd_q    <= opd_d;
      f3_q     <= f3_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
    end
  end

  assign result_o = result_q;
  assign busy_o   = state_q != MD_IDLE;

  ex_muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .div_i     (f3_q[2]),
    .load_val_i(load_val),
    .opd_i     (opd_q),
    .step_o    (step_val)
  );

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv against an arithmetic reference model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_ex_muldiv;

  localparam logic [6:0]  OP     = 7'b0110011;
  localparam logic [6:0]  OP32   = 7'b0111011;
  localparam logic [6:0]  ADDI   = 7'b0010011;
  localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode_i = ADDI;
  logic [2:0]  funct3_i = 3'b000;
  logic [6:0]  funct7_i = 7'b0;
  logic [63:0] rs1_data_i = '0;
  logic [63:0] rs2_data_i = '0;
  logic        flush_i = 1'b0;
  logic [63:0] result_o;
  logic        valid_o;
  logic        stall_req_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .opcode_i   (opcode_i),
    .funct3_i   (funct3_i),
    .funct7_i   (funct7_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .flush_i    (flush_i),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .stall_req_o(stall_req_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_result(input logic [2:0] f3,
                                             input logic word,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
    logic signed [127:0] pa, pb, pp;
    logic signed [63:0]  sa, sb, sq;
    logic signed [31:0]  wa, wb, wq;
    logic [31:0]         ua, ub, r32;
    logic [63:0]         r;
    r = '0;
    if (!word) begin
      sa = a;
      sb = b;
      if (!f3[2]) begin
        pa = (f3 == 3'b011) ? {64'b0, a} : {{64{a[63]}}, a};
        pb = f3[1] ? {64'b0, b} : {{64{b[63]}}, b};
        pp = pa * pb;
        r  = (f3 == 3'b000) ? pp[63:0] : pp[127:64];
      end else if (f3 == 3'b100) begin
        if (b == 0) r = ONES64;
        else if (a == MIN64 && b == ONES64) r = MIN64;
        else begin sq = sa / sb; r = sq; end
      end else if (f3 == 3'b101) begin
        if (b == 0) r = ONES64;
        else r = a / b;
      end else if (f3 == 3'b110) begin
        if (b == 0) r = a;
        else if (a == MIN64 && b == ONES64) r = 0;
        else begin sq = sa % sb; r = sq; end
      end else begin
        if (b == 0) r = a;
        else r = a % b;
      end
    end else begin
      ua = a[31:0];
      ub = b[31:0];
      wa = ua;
      wb = ub;
      r32 = '0;
      if (f3 == 3'b000) r32 = ua * ub;
      else if (f3 == 3'b100) begin
        if (ub == 0) r32 = 32'hFFFF_FFFF;
        else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = ua;
        else begin wq = wa / wb; r32 = wq; end
      end else if (f3 == 3'b101) begin
        if (ub == 0) r32 = 32'hFFFF_FFFF;
        else r32 = ua / ub;
      end else if (f3 == 3'b110) begin
        if (ub == 0) r32 = ua;
        else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = 0;
        else begin wq = wa % wb; r32 = wq; end
      end else begin
        if (ub == 0) r32 = ua;
        else r32 = ua % ub;
      end
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic word,
                                     input logic [63:0] a, input logic [63:0] b);
    bit special;
    if (word)
      special = f3[2] && (b[31:0] == 0 || (!f3[0] && a[31:0] == 32'h8000_0000
                && b[31:0] == 32'hFFFF_FFFF));
    else
      special = f3[2] && (b == 0 || (!f3[0] && a == MIN64 && b == ONES64));
    if (special) return 1;
    return word ? 33 : 65;
  endfunction

  task automatic drive_bubble();
    opcode_i   = ADDI;
    funct3_i   = 3'b000;
    funct7_i   = 7'b0;
    rs1_data_i = '0;
    rs2_data_i = '0;
  endtask

  task automatic drive_mop(input logic [2:0] f3, input logic word,
                           input logic [63:0] a, input logic [63:0] b);
    opcode_i   = word ? OP32 : OP;
    funct3_i   = f3;
    funct7_i   = 7'b0000001;
    rs1_data_i = a;
    rs2_data_i = b;
  endtask

  // Presents one M-op and follows it to its DONE cycle; leaves it driven.
  task automatic run_op(input logic [2:0] f3, input logic word,
                        input logic [63:0] a, input logic [63:0] b);
    int          lat;
    logic [63:0] exp;
    bit          seq_ok;
    lat    = ref_latency(f3, word, a, b);
    exp    = ref_result(f3, word, a, b);
    seq_ok = 1;
    @(negedge clk);
    drive_mop(f3, word, a, b);
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c < lat && (stall_req_o !== 1'b1 || valid_o !== 1'b0 ||
                      (c > 0 && busy_o !== 1'b1)))
        seq_ok = 0;
    end
    checks++;
    if (valid_o !== 1'b1 || stall_req_o !== 1'b0 || !seq_ok) begin
      errors++;
      $display("FAIL handshake f3=%0d w=%0d lat=%0d: valid=%b stall=%b seq_ok=%0d, required valid=1 stall=0 seq_ok=1",
               f3, word, lat, valid_o, stall_req_o, seq_ok);
    end
    checks++;
    if (result_o !== exp) begin
      errors++;
      $display("FAIL result f3=%0d w=%0d a=%h b=%h: got %h, required %h",
               f3, word, a, b, result_o, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_bubble();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (result_o !== 64'h0 || valid_o !== 1'b0 || stall_req_o !== 1'b0 ||
        busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: result=%h valid=%b stall=%b busy=%b, required all 0",
               result_o, valid_o, stall_req_o, busy_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'b011, 1'b0, ONES64, ONES64);
    run_op(3'b001, 1'b0, ONES64, ONES64);
    run_op(3'b010, 1'b0, ONES64, 64'd2);
    run_op(3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);
    run_op(3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);
    run_op(3'b101, 1'b0, 64'd5, 64'd0);
    run_op(3'b110, 1'b0, 64'd5, 64'd0);
    run_op(3'b100, 1'b0, MIN64, ONES64);
    run_op(3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
    run_op(3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'd0);
    run_op(3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd3);
  endtask

  task automatic test_hold();
    logic [63:0] exp;
    exp = ref_result(3'b101, 1'b0, 64'd1000, 64'd7);
    run_op(3'b101, 1'b0, 64'd1000, 64'd7);
    @(negedge clk);
    drive_bubble();
    #1;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== exp) begin
      errors++;
      $display("FAIL hold: valid=%b busy=%b result=%h, required 0 0 %h",
               valid_o, busy_o, result_o, exp);
    end
  endtask

  task automatic test_not_mop();
    bit bad;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_mop(3'(1 + (i % 3)), 1'b1, 64'd9, 64'd3);
      if (i >= 3) funct7_i = 7'b0;
      if (i == 5) opcode_i = 7'b1111111;
      #1;
      if (stall_req_o !== 1'b0 || valid_o !== 1'b0) bad = 1;
    end
    @(negedge clk);
    drive_bubble();
    #1;
    checks++;
    if (bad || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL not_mop: stall/valid seen=%0d busy=%b, required 0 0",
               bad, busy_o);
    end
  endtask

  task automatic test_flush();
    bit vseen;
    vseen = 0;
    @(negedge clk);
    drive_mop(3'b100, 1'b0, 64'd100, 64'd7);
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (valid_o !== 1'b0) vseen = 1;
      @(negedge clk);
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_req_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: stall=%b valid=%b, required 0 0",
               stall_req_o, valid_o);
    end
    @(negedge clk);
    flush_i  = 1'b0;
    drive_mop(3'b000, 1'b0, 64'd1, 64'd2);
    funct7_i = 7'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || stall_req_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: busy=%b stall=%b valid=%b, required 0 0 0",
               busy_o, stall_req_o, valid_o);
    end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      #1;
      if (valid_o !== 1'b0 || busy_o !== 1'b0) vseen = 1;
    end
    checks++;
    if (vseen) begin
      errors++;
      $display("FAIL flush_no_valid: valid or busy seen=1, required 0");
    end
    @(negedge clk);
    drive_mop(3'b000, 1'b0, 64'd3, 64'd5);
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_stall: stall=%b, required 0", stall_req_o);
    end
    @(negedge clk);
    flush_i = 1'b0;
    drive_bubble();
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_start: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_mid_reset();
    bit vseen;
    vseen = 0;
    @(negedge clk);
    drive_mop(3'b100, 1'b0, 64'd100, 64'd7);
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (valid_o !== 1'b0) vseen = 1;
      @(negedge clk);
    end
    rst = 1'b1;
    drive_bubble();
    @(negedge clk);
    #1;
    checks++;
    if (vseen || result_o !== 64'h0 || valid_o !== 1'b0 ||
        stall_req_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: vseen=%0d result=%h valid=%b stall=%b busy=%b, required 0 0 0 0 0",
               vseen, result_o, valid_o, stall_req_o, busy_o);
    end
    rst = 1'b0;
    run_op(3'b000, 1'b0, 64'd3, 64'd4);
    checks++;
    if (result_o !== 64'd12) begin
      errors++;
      $display("FAIL mid_reset_mul: got %h, required %h", result_o, 64'd12);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'b100, 1'b1, 64'd50, 64'hFFFF_FFFF_FFFF_FFF9);
    run_op(3'b000, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd16);
    run_op(3'b111, 1'b0, 64'd17, 64'd5);
  endtask

  function automatic logic [63:0] pick_operand();
    unique case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES64;
      2: return MIN64;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'({$urandom_range(0, 255)});
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  f3;
    logic        word;
    logic [63:0] a, b;
    for (int i = 0; i < 30; i++) begin
      word = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      if (word && f3 != 3'b000 && !f3[2]) f3 = 3'b100;
      a = pick_operand();
      b = pick_operand();
      run_op(f3, word, a, b);
    end
    @(negedge clk);
    drive_bubble();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_not_mop();
    test_flush();
    test_mid_reset();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
